// File: rtl/apb_slot_arbiter.sv
// Round-robin, time-sliced arbiter sharing one APB master port among NREQ requesters.
// Optional macro APB_ARB_LOCK_EN adds a lock input and a HOLD state that defers expiry.
module apb_slot_arbiter #(
    parameter int NREQ     = 4,
    parameter int DEF_SLOT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [4:0]              slot_len,
`ifdef APB_ARB_LOCK_EN
    input  logic                    lock,
`endif
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_id,
    output logic                    busy,
    output logic                    expire,
    output logic [4:0]              slot_cnt
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]  gnt_id_q, gnt_id_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [4:0]      slot_cnt_q, slot_cnt_d;
    logic [4:0]      slot_lim_q, slot_lim_d;
    logic            expire_q, expire_d;

    logic            win_vld;
    logic [IDW-1:0]  win_id;
    logic [IDW-1:0]  cand;
    logic            owner_req;
    logic            slot_last;
    logic            lock_hold;
    logic [IDW-1:0]  ptr_next;

    // First set request at or after ptr, wrapping at NREQ-1 (works for non-power-of-2 NREQ).
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (int'(ptr_q) + i >= NREQ)
                cand = IDW'(int'(ptr_q) + i - NREQ);
            else
                cand = IDW'(int'(ptr_q) + i);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    assign owner_req = req[gnt_id_q];
    assign slot_last = (slot_cnt_q == slot_lim_q - 5'd1);
    assign ptr_next  = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + 1'b1;

`ifdef APB_ARB_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        ptr_d      = ptr_q;
        slot_cnt_d = slot_cnt_q;
        slot_lim_d = slot_lim_q;
        expire_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    gnt_d      = NREQ'(1) << win_id;
                    gnt_id_d   = win_id;
                    slot_cnt_d = 5'd0;
                    slot_lim_d = (slot_len == 5'd0) ? 5'(DEF_SLOT) : slot_len;
                    state_d    = GRANT;
                end
            end
            GRANT, HOLD: begin
                if (!owner_req) begin
                    // Owner release wins over a coincident expiry: no expire pulse.
                    gnt_d      = '0;
                    slot_cnt_d = 5'd0;
                    ptr_d      = ptr_next;
                    state_d    = IDLE;
                end else if (state_q == HOLD || slot_last) begin
                    if (lock_hold) begin
                        state_d    = HOLD;
                        slot_cnt_d = slot_cnt_q;
                    end else begin
                        gnt_d      = '0;
                        slot_cnt_d = 5'd0;
                        expire_d   = 1'b1;
                        ptr_d      = ptr_next;
                        state_d    = IDLE;
                    end
                end else begin
                    slot_cnt_d = slot_cnt_q + 5'd1;
                end
            end
            default: begin
                gnt_d      = '0;
                slot_cnt_d = 5'd0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            ptr_q      <= '0;
            slot_cnt_q <= 5'd0;
            slot_lim_q <= 5'd0;
            expire_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            ptr_q      <= ptr_d;
            slot_cnt_q <= slot_cnt_d;
            slot_lim_q <= slot_lim_d;
            expire_q   <= expire_d;
        end
    end

    assign gnt      = gnt_q;
    assign gnt_id   = gnt_id_q;
    assign busy     = |gnt_q;
    assign expire   = expire_q;
    assign slot_cnt = slot_cnt_q;

endmodule

// File: tb/tb_apb_slot_arbiter.sv
// Directed bench for apb_slot_arbiter (NREQ=4, DEF_SLOT=8); lock scenario built only with APB_ARB_LOCK_EN.
module tb_apb_slot_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [4:0] slot_len;
`ifdef APB_ARB_LOCK_EN
    logic       lock;
`endif
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       expire;
    logic [4:0] slot_cnt;

    int tests = 0;
    int fails = 0;

    apb_slot_arbiter #(.NREQ(4), .DEF_SLOT(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .slot_len (slot_len),
`ifdef APB_ARB_LOCK_EN
        .lock     (lock),
`endif
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .busy     (busy),
        .expire   (expire),
        .slot_cnt (slot_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        req      = 4'b0000;
        slot_len = 5'd0;
`ifdef APB_ARB_LOCK_EN
        lock     = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({gnt, gnt_id, busy, expire, slot_cnt} !== 13'd0) begin
            fails++;
            $display("FAIL reset_state gnt=%b id=%0d busy=%b exp=%b cnt=%0d expected all zero",
                     gnt, gnt_id, busy, expire, slot_cnt);
        end
    endtask

    task automatic test_single_default_slot();
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 8; c++) begin
            step();
            tests++;
            if (gnt !== 4'b0001 || busy !== 1'b1 || slot_cnt !== 5'(c) || expire !== 1'b0) begin
                fails++;
                $display("FAIL single_grant c=%0d gnt=%b busy=%b cnt=%0d exp=%b expected gnt=0001 busy=1 cnt=%0d exp=0",
                         c, gnt, busy, slot_cnt, expire, c);
            end
        end
        step();
        tests++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || expire !== 1'b1 || slot_cnt !== 5'd0) begin
            fails++;
            $display("FAIL single_expire gnt=%b busy=%b exp=%b cnt=%0d expected gnt=0000 busy=0 exp=1 cnt=0",
                     gnt, busy, expire, slot_cnt);
        end
        step();
        tests++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0 || expire !== 1'b0) begin
            fails++;
            $display("FAIL single_regrant gnt=%b id=%0d exp=%b expected gnt=0001 id=0 exp=0",
                     gnt, gnt_id, expire);
        end
        req = 4'b0000;
        step();
        tests++;
        if (gnt !== 4'b0000 || expire !== 1'b0) begin
            fails++;
            $display("FAIL single_release gnt=%b exp=%b expected gnt=0000 exp=0", gnt, expire);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        do_reset();
        req      = 4'b1111;
        slot_len = 5'd3;
        for (int g = 0; g < 5; g++) begin
            exp_gnt = 4'b0001 << (g % 4);
            for (int c = 0; c < 3; c++) begin
                step();
                tests++;
                if (gnt !== exp_gnt || gnt_id !== 2'(g % 4) || slot_cnt !== 5'(c)) begin
                    fails++;
                    $display("FAIL rr_grant g=%0d c=%0d gnt=%b id=%0d cnt=%0d expected gnt=%b id=%0d cnt=%0d",
                             g, c, gnt, gnt_id, slot_cnt, exp_gnt, g % 4, c);
                end
            end
            step();
            tests++;
            if (gnt !== 4'b0000 || expire !== 1'b1 || gnt_id !== 2'(g % 4)) begin
                fails++;
                $display("FAIL rr_gap g=%0d gnt=%b exp=%b id=%0d expected gnt=0000 exp=1 id=%0d",
                         g, gnt, expire, gnt_id, g % 4);
            end
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_owner_release();
        do_reset();
        slot_len = 5'd10;
        req      = 4'b0100;
        step();
        step();
        tests++;
        if (gnt !== 4'b0100 || slot_cnt !== 5'd1) begin
            fails++;
            $display("FAIL rel_owner gnt=%b cnt=%0d expected gnt=0100 cnt=1", gnt, slot_cnt);
        end
        req = 4'b1010;
        step();
        tests++;
        if (gnt !== 4'b0000 || expire !== 1'b0 || busy !== 1'b0 || gnt_id !== 2'd2) begin
            fails++;
            $display("FAIL rel_drop gnt=%b exp=%b busy=%b id=%0d expected gnt=0000 exp=0 busy=0 id=2",
                     gnt, expire, busy, gnt_id);
        end
        step();
        tests++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
            fails++;
            $display("FAIL rel_next gnt=%b id=%0d expected gnt=1000 id=3", gnt, gnt_id);
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_slot_len_change();
        do_reset();
        slot_len = 5'd5;
        req      = 4'b0001;
        step();
        slot_len = 5'd2;
        step();
        step();
        step();
        step();
        tests++;
        if (gnt !== 4'b0001 || slot_cnt !== 5'd4) begin
            fails++;
            $display("FAIL len_hold gnt=%b cnt=%0d expected gnt=0001 cnt=4", gnt, slot_cnt);
        end
        step();
        tests++;
        if (gnt !== 4'b0000 || expire !== 1'b1) begin
            fails++;
            $display("FAIL len_expire5 gnt=%b exp=%b expected gnt=0000 exp=1", gnt, expire);
        end
        step();
        step();
        tests++;
        if (gnt !== 4'b0001 || slot_cnt !== 5'd1) begin
            fails++;
            $display("FAIL len_second gnt=%b cnt=%0d expected gnt=0001 cnt=1", gnt, slot_cnt);
        end
        step();
        tests++;
        if (gnt !== 4'b0000 || expire !== 1'b1) begin
            fails++;
            $display("FAIL len_expire2 gnt=%b exp=%b expected gnt=0000 exp=1", gnt, expire);
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0001;
        step();
        step();
        step();
        tests++;
        if (gnt !== 4'b0001 || slot_cnt !== 5'd2) begin
            fails++;
            $display("FAIL arst_pre gnt=%b cnt=%0d expected gnt=0001 cnt=2", gnt, slot_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || slot_cnt !== 5'd0) begin
            fails++;
            $display("FAIL arst_now gnt=%b busy=%b cnt=%0d expected gnt=0000 busy=0 cnt=0",
                     gnt, busy, slot_cnt);
        end
        req = 4'b0110;
        step();
        rst = 1'b0;
        step();
        tests++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
            fails++;
            $display("FAIL arst_after gnt=%b id=%0d expected gnt=0010 id=1", gnt, gnt_id);
        end
        req = 4'b0000;
        step();
    endtask

`ifdef APB_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        slot_len = 5'd2;
        req      = 4'b0001;
        lock     = 1'b1;
        step();
        for (int c = 0; c < 5; c++) begin
            step();
            tests++;
            if (gnt !== 4'b0001 || slot_cnt !== 5'd1 || expire !== 1'b0) begin
                fails++;
                $display("FAIL lock_hold c=%0d gnt=%b cnt=%0d exp=%b expected gnt=0001 cnt=1 exp=0",
                         c, gnt, slot_cnt, expire);
            end
        end
        lock = 1'b0;
        step();
        tests++;
        if (gnt !== 4'b0000 || expire !== 1'b1) begin
            fails++;
            $display("FAIL lock_exit gnt=%b exp=%b expected gnt=0000 exp=1", gnt, expire);
        end
        req = 4'b0000;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_single_default_slot();
        test_round_robin();
        test_owner_release();
        test_slot_len_change();
        test_async_reset();
`ifdef APB_ARB_LOCK_EN
        test_lock();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
